mac_rx_frame_buffer: RTL



---
 rtl/mac_rx_frame_buffer_pkg.sv | 23 ++
 rtl/mac_rx_frame_buffer_len_fifo.sv | 45 ++++
 rtl/mac_rx_frame_buffer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mac_rx_frame_buffer_pkg.sv
// Shared types and constants for the MAC rx frame buffer.
package mac_rx_frame_buffer_pkg;

  localparam int unsigned RX_WORD_W = 72;
  localparam int unsigned LEN_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } wr_state_e;

  // Descriptor layout is {len[LEN_W-1:0], words[ADDR_W:0]}: the word count sits in the low bits.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/mac_rx_frame_buffer_len_fifo.sv
// rx_len_fifo: synchronous first-word-fall-through descriptor FIFO, depth 2**AW.
module rx_len_fifo #(
  parameter int unsigned W  = 26,
  parameter int unsigned AW = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2**AW];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (wr_en_i && !full_o) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i && !full_o) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_rx_frame_buffer.sv
// MAC rx frame buffer: ring-buffered frames committed on good_frame, pulled word-by-word by the DMA.
// Define MAC_RX_BUF_STATS_EN to implement the bad/drop frame counters (otherwise they read 0).
module mac_rx_frame_buffer
  import mac_rx_frame_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W          = 9,
  parameter int unsigned LEN_AW          = 4,
  parameter int unsigned MAX_FRAME_BYTES = 2048
) (
  input  logic        mac_clk,
  input  logic        mac_rst,
  input  logic [63:0] mac_rx_data,
  input  logic [7:0]  mac_rx_data_valid,
  input  logic        mac_rx_good_frame,
  input  logic        mac_rx_bad_frame,
  output logic        rd_frame_ready,
  output logic [15:0] rd_frame_len,
  input  logic        rd_en,
  output logic [63:0] rd_data,
  output logic [7:0]  rd_data_valid,
  output logic        rd_last,
  output logic [31:0] bad_frame_cnt,
  output logic [31:0] drop_frame_cnt
);

  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned DESC_W = LEN_W + PTR_W;
  localparam logic [PTR_W-1:0] RING_WORDS = {1'b1, {ADDR_W{1'b0}}};

  logic [RX_WORD_W-1:0] ram_q [2**ADDR_W];

  wr_state_e        state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] commit_ptr_q, commit_ptr_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [PTR_W-1:0] word_cnt_q, word_cnt_d;
  logic             ram_we, desc_push, bad_end, drop_end, in_frame, drop_now;

  logic [PTR_W-1:0]  rd_ptr_q, rd_idx_q;
  logic [63:0]       rd_data_q;
  logic [7:0]        rd_valid_q;
  logic              rd_last_q;
  logic              desc_full, desc_empty, desc_pop, rd_fire, rd_is_last;
  logic [DESC_W-1:0] desc_head;
  logic [PTR_W-1:0]  head_words;
  logic [LEN_W-1:0]  head_len;

  logic ring_full, has_data, end_pulse;
  assign ring_full = ((wr_ptr_q - rd_ptr_q) == RING_WORDS);
  assign has_data  = |mac_rx_data_valid;
  assign end_pulse = mac_rx_good_frame | mac_rx_bad_frame;

  // A word arriving with the end pulse belongs to the frame, so the write is resolved first
  // and the end pulse then acts on the updated counts; a drop decided this cycle takes precedence.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    ram_we       = 1'b0;
    desc_push    = 1'b0;
    bad_end      = 1'b0;
    drop_end     = 1'b0;
    in_frame     = 1'b0;
    drop_now     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (has_data) begin
          if (desc_full) begin
            drop_now = 1'b1;
          end else begin
            in_frame   = 1'b1;
            byte_cnt_d = '0;
            word_cnt_d = '0;
          end
        end
      end
      ST_RECV: in_frame = 1'b1;
      ST_DROP: drop_now = 1'b1;
      default: state_d = ST_IDLE;
    endcase

    if (in_frame && has_data) begin
      if (ring_full) begin
        drop_now = 1'b1;
      end else begin
        ram_we     = 1'b1;
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        byte_cnt_d = byte_cnt_d + LEN_W'(popcount8(mac_rx_data_valid));
        word_cnt_d = word_cnt_d + PTR_W'(1);
        if (byte_cnt_d > LEN_W'(MAX_FRAME_BYTES)) begin
          drop_now = 1'b1;
        end
      end
    end

    if (drop_now) begin
      state_d = ST_DROP;
      if (end_pulse) begin
        drop_end = 1'b1;
        state_d  = ST_IDLE;
      end
    end else if (in_frame) begin
      state_d = ST_RECV;
      if (mac_rx_bad_frame) begin
        bad_end = 1'b1;
        state_d = ST_IDLE;
      end else if (mac_rx_good_frame) begin
        commit_ptr_d = wr_ptr_d;
        desc_push    = 1'b1;
        state_d      = ST_IDLE;
      end
    end

    if (bad_end || drop_end) begin
      wr_ptr_d = commit_ptr_q;
    end
  end

  always_ff @(posedge mac_clk or posedge mac_rst) begin
    if (mac_rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  always_ff @(posedge mac_clk) begin
    if (ram_we) begin
      ram_q[wr_ptr_q[ADDR_W-1:0]] <= {mac_rx_data_valid, mac_rx_data};
    end
  end

  rx_len_fifo #(
    .W  (DESC_W),
    .AW (LEN_AW)
  ) u_len_fifo (
    .clk_i     (mac_clk),
    .rst_i     (mac_rst),
    .wr_en_i   (desc_push),
    .wr_data_i ({byte_cnt_d, word_cnt_d}),
    .rd_en_i   (desc_pop),
    .rd_data_o (desc_head),
    .full_o    (desc_full),
    .empty_o   (desc_empty)
  );

  assign head_words = desc_head[PTR_W-1:0];
  assign head_len   = desc_head[DESC_W-1:PTR_W];
  assign rd_fire    = rd_en && !desc_empty;
  assign rd_is_last = (rd_idx_q == (head_words - PTR_W'(1)));
  assign desc_pop   = rd_fire && rd_is_last;

  always_ff @(posedge mac_clk or posedge mac_rst) begin
    if (mac_rst) begin
      rd_ptr_q   <= '0;
      rd_idx_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      rd_last_q  <= 1'b0;
    end else if (rd_fire) begin
      rd_data_q  <= ram_q[rd_ptr_q[ADDR_W-1:0]][63:0];
      rd_valid_q <= ram_q[rd_ptr_q[ADDR_W-1:0]][71:64];
      rd_last_q  <= rd_is_last;
      rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
      rd_idx_q   <= rd_is_last ? '0 : rd_idx_q + PTR_W'(1);
    end
  end

  assign rd_frame_ready = !desc_empty;
  assign rd_frame_len   = desc_empty ? '0 : head_len;
  assign rd_data        = rd_data_q;
  assign rd_data_valid  = rd_valid_q;
  assign rd_last        = rd_last_q;

`ifdef MAC_RX_BUF_STATS_EN
  logic [31:0] bad_cnt_q, drop_cnt_q;

  always_ff @(posedge mac_clk or posedge mac_rst) begin
    if (mac_rst) begin
      bad_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (bad_end && (bad_cnt_q != '1)) begin
        bad_cnt_q <= bad_cnt_q + 32'd1;
      end
      if (drop_end && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + 32'd1;
      end
    end
  end

  assign bad_frame_cnt  = bad_cnt_q;
  assign drop_frame_cnt = drop_cnt_q;
`else
  assign bad_frame_cnt  = '0;
  assign drop_frame_cnt = '0;
`endif

endmodule
